// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit issuing on an SRAM-like bus.
// In-order tracker FIFO pairs bus responses with their originating request.
module mem_lsu #(
    parameter int DEPTH        = 2,
    parameter int REG_AW       = 5,
    parameter int PHYS_MASK_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    input  logic [REG_AW-1:0] req_wd,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              wb_valid,
    output logic              wb_wreg,
    output logic [REG_AW-1:0] wb_wd,
    output logic [31:0]       wb_wdata,
    output logic [31:0]       wb_pc,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [31:0]       exc_badvaddr,
    output logic [31:0]       exc_pc,
    output logic              busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;

    logic [3:0]        op_mem  [DEPTH];
    logic [1:0]        off_mem [DEPTH];
    logic [REG_AW-1:0] wd_mem  [DEPTH];
    logic [31:0]       pc_mem  [DEPTH];

    logic              wb_valid_q, wb_valid_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [REG_AW-1:0] wb_wd_q, wb_wd_d;
    logic [31:0]       wb_wdata_q, wb_wdata_d;
    logic [31:0]       wb_pc_q, wb_pc_d;

    logic              exc_valid_q, exc_valid_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [31:0]       exc_badvaddr_q, exc_badvaddr_d;
    logic [31:0]       exc_pc_q, exc_pc_d;

    logic              is_load;
    logic              is_store;
    logic [1:0]        size;
    logic              misal;
    logic              aligned_op;
    logic              not_full;
    logic              push;
    logic              pop;

    logic [3:0]        head_op;
    logic [1:0]        head_off;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    // Operation decode and alignment check
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd0;
        case (req_op)
            4'd0, 4'd1: begin is_load = 1'b1;  size = 2'd0; end
            4'd2, 4'd3: begin is_load = 1'b1;  size = 2'd1; end
            4'd4:       begin is_load = 1'b1;  size = 2'd2; end
            4'd8:       begin is_store = 1'b1; size = 2'd0; end
            4'd9:       begin is_store = 1'b1; size = 2'd1; end
            4'd10:      begin is_store = 1'b1; size = 2'd2; end
            default:    ;
        endcase
        misal = ((size == 2'd1) && req_addr[0]) ||
                ((size == 2'd2) && (req_addr[1:0] != 2'b00));
    end

    assign aligned_op = (is_load || is_store) && !misal;
    assign not_full   = (count_q != CW'(DEPTH));
    assign push       = req_valid && aligned_op && not_full && data_addr_ok;
    assign pop        = data_data_ok && (count_q != '0);

    // Bus request drive; misaligned and NOP requests are consumed without bus traffic
    always_comb begin
        data_req   = req_valid && aligned_op && not_full && !rst;
        data_wr    = data_req && is_store;
        data_size  = size;
        data_addr  = (PHYS_MASK_EN != 0) ? {3'b000, req_addr[28:0]} : req_addr;
        data_wdata = 32'd0;
        if (is_store) begin
            case (size)
                2'd0:    data_wdata = {4{req_wdata[7:0]}};
                2'd1:    data_wdata = {2{req_wdata[15:0]}};
                default: data_wdata = req_wdata;
            endcase
        end
        req_ready  = aligned_op ? (data_addr_ok && not_full) : 1'b1;
    end

    // Head entry load-data extraction
    always_comb begin
        head_op  = op_mem[rptr_q];
        head_off = off_mem[rptr_q];
        case (head_off)
            2'd0:    rd_byte = data_rdata[7:0];
            2'd1:    rd_byte = data_rdata[15:8];
            2'd2:    rd_byte = data_rdata[23:16];
            default: rd_byte = data_rdata[31:24];
        endcase
        rd_half = head_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (head_op)
            4'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            4'd1:    load_data = {24'd0, rd_byte};
            4'd2:    load_data = {{16{rd_half[15]}}, rd_half};
            4'd3:    load_data = {16'd0, rd_half};
            4'd4:    load_data = data_rdata;
            default: load_data = 32'd0;
        endcase
    end

    // Next-state for occupancy, pointers, completion and exception registers
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
        wptr_d = wptr_q;
        if (push) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        rptr_d = rptr_q;
        if (pop) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end

        wb_valid_d = pop;
        wb_wreg_d  = wb_wreg_q;
        wb_wd_d    = wb_wd_q;
        wb_wdata_d = wb_wdata_q;
        wb_pc_d    = wb_pc_q;
        if (pop) begin
            wb_wreg_d  = !head_op[3];
            wb_wd_d    = wd_mem[rptr_q];
            wb_wdata_d = load_data;
            wb_pc_d    = pc_mem[rptr_q];
        end

        exc_valid_d    = req_valid && (is_load || is_store) && misal;
        exc_code_d     = exc_code_q;
        exc_badvaddr_d = exc_badvaddr_q;
        exc_pc_d       = exc_pc_q;
        if (exc_valid_d) begin
            exc_code_d     = is_store ? 5'd5 : 5'd4;
            exc_badvaddr_d = req_addr;
            exc_pc_d       = req_pc;
        end
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            wb_valid_q     <= 1'b0;
            wb_wreg_q      <= 1'b0;
            wb_wd_q        <= '0;
            wb_wdata_q     <= '0;
            wb_pc_q        <= '0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= '0;
            exc_badvaddr_q <= '0;
            exc_pc_q       <= '0;
        end else begin
            count_q        <= count_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            wb_valid_q     <= wb_valid_d;
            wb_wreg_q      <= wb_wreg_d;
            wb_wd_q        <= wb_wd_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_pc_q        <= wb_pc_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_badvaddr_q <= exc_badvaddr_d;
            exc_pc_q       <= exc_pc_d;
        end
    end

    // Tracker payload; contents are only read while count marks them live
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wptr_q]  <= req_op;
            off_mem[wptr_q] <= req_addr[1:0];
            wd_mem[wptr_q]  <= req_wd;
            pc_mem[wptr_q]  <= req_pc;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_wreg      = wb_wreg_q;
    assign wb_wd        = wb_wd_q;
    assign wb_wdata     = wb_wdata_q;
    assign wb_pc        = wb_pc_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_badvaddr = exc_badvaddr_q;
    assign exc_pc       = exc_pc_q;
    assign busy         = (count_q != '0);

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DEPTH, default 2, maximum number of outstanding bus transactions; legal values are 1, 2, 4 and 8.
REQ-002 Parameter REG_AW, default 5, is the destination register address width.
REQ-003 Parameter PHYS_MASK_EN, default 1: 1 means data_addr = {3'b0, addr[28:0]}; 0 means data_addr = addr.
REQ-004 clk  in  1  single clock; all flops are rising-edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 req_valid  in  1  issue request present.
REQ-007 req_ready  out  1  issue request consumed this cycle.
REQ-008 req_op  in  4  operation: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, 10 SW; all other codes are NOP.
REQ-009 req_addr / req_wdata / req_pc  in  32 each  virtual address, store source register, instruction PC.
REQ-010 req_wd  in  REG_AW  load destination register.
REQ-011 data_req, data_wr  out  1 each; data_size  out  2; data_addr, data_wdata  out  32 each  SRAM-like bus request.
REQ-012 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32  bus handshake and read data.
REQ-013 wb_valid, wb_wreg  out  1 each; wb_wd  out  REG_AW; wb_wdata, wb_pc  out  32 each  completion port.
REQ-014 exc_valid  out  1; exc_code  out  5; exc_badvaddr, exc_pc  out  32 each  address-error report.
REQ-015 busy  out  1  high when count != 0.

Function
REQ-016 Misaligned request: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-017 Valid aligned load/store with count<DEPTH: data_req=1 combinationally, data_wr=1 for stores only, data_size = 0/1/2 for byte/half/word.
REQ-018 data_wdata formats: SB {4{b[7:0]}}, SH {2{b[15:0]}}, SW b; data_wdata = 0 for loads.
REQ-019 Aligned load/store: req_ready = data_addr_ok && count<DEPTH; acceptance pushes {op, addr[1:0], wd, pc} into an in-order tracker FIFO of DEPTH entries.
REQ-020 count==DEPTH: data_req=0 and req_ready=0 (full back-pressure).
REQ-021 Misaligned request: req_ready=1 and data_req=0; next cycle exc_valid=1 for one cycle with exc_code 4 (load) or 5 (store), exc_badvaddr=req_addr, exc_pc=req_pc.
REQ-022 NOP op: req_ready=1, data_req=0, no other effect.
REQ-023 data_data_ok with count>0 pops the FIFO head; next cycle wb_valid=1 for one cycle with wb_wd/wb_pc taken from the head entry and wb_wreg=1 for loads, 0 for stores.
REQ-024 Load data selected from data_rdata by saved addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; wb_wdata=0 for stores.
REQ-025 Simultaneous push and pop leaves count unchanged; the FIFO pointers wrap modulo DEPTH.
REQ-026 data_data_ok while count==0 is ignored and produces no wb_valid.
REQ-027 Completions leave in issue order; load-use latency is 1 cycle after data_data_ok.
REQ-028 A response and a new acceptance in the same cycle are both processed, including when count==DEPTH-1.

Reset
REQ-029 rst=1 clears count, FIFO pointers, wb_* and exc_* registers to 0 immediately; busy=0 and data_req=0 while rst=1.
REQ-030 Bus responses arriving after a reset that occurred mid-transaction are dropped under REQ-026.

Verification
REQ-031 LW addr 0x8000_0010, addr_ok same cycle, data_ok 3 cycles later with rdata 0xDEADBEEF -> data_addr 0x0000_0010, then wb_valid with wb_wdata 0xDEADBEEF, wb_wreg=1.
REQ-032 LB addr 0x...03, rdata 0x80FF_0000 -> wb_wdata 0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr 0x...02 -> 0xFFFF_80FF.
REQ-033 SH addr 0x...01, pc 0xBFC0_0100 -> no data_req; next cycle exc_valid=1, exc_code 5, exc_badvaddr 0x...01, exc_pc 0xBFC0_0100.
REQ-034 DEPTH=2: three back-to-back SW with addr_ok held 1 and no data_ok -> two accepted, third stalls (req_ready=0) until the first data_ok, then is accepted; three wb_valid pulses in order, all with wb_wreg=0.
REQ-035 Two loads outstanding, rst pulsed, then two stray data_ok -> busy=0 and no wb_valid after reset.
